// File: rtl/uart_loader_pkg.sv
// rtl/uart_loader_pkg.sv - shared state encoding and constants for the UART word loader
package uart_loader_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2
    } loader_state_t;

    localparam int BYTES_PER_WORD         = 4;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1_000_000;

endpackage

// File: rtl/uart_idle_timer.sv
// rtl/uart_idle_timer.sv - inter-byte idle timer with a one-cycle expire pulse
module uart_idle_timer
    import uart_loader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // Expiry is independent of clear so a byte landing on the expiry cycle still drops the old word.
    assign expire = count_en && (count == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear || expire) begin
            count <= '0;
        end else if (count_en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_word_loader.sv
// rtl/uart_word_loader.sv - packs UART bytes into little-endian words for memory; UART_LOADER_CHECKSUM_EN adds a running word sum
module uart_word_loader
    import uart_loader_pkg::*;
#(
    parameter int ADDR_WIDTH     = 12,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_valid,
    input  logic                  rx_err,
    input  logic                  enable,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_data,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  busy,
    output logic                  overflow,
    output logic [31:0]           checksum
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
    localparam logic [1:0]            LAST_IDX  = 2'(BYTES_PER_WORD - 1);

    loader_state_t         state;
    logic [1:0]            idx;
    logic [23:0]           word;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  take;
    logic                  expire;

    assign take = rx_valid && enable && !rx_err;

    uart_idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    ((state != COLLECT) || rx_valid),
        .count_en (state == COLLECT),
        .expire   (expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= 2'd0;
            word       <= '0;
            addr       <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            word_count <= '0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (take && !overflow) begin
                        word[7:0] <= rx_byte;
                        idx       <= 2'd1;
                        busy      <= 1'b1;
                        state     <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (!enable || rx_err || (expire && !rx_valid)) begin
                        idx   <= 2'd0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (expire) begin
                        word[7:0] <= rx_byte;
                        idx       <= 2'd1;
                    end else if (rx_valid) begin
                        if (idx == LAST_IDX) begin
                            mem_we   <= 1'b1;
                            mem_addr <= addr;
                            mem_data <= {rx_byte, word};
                            idx      <= 2'd0;
                            busy     <= 1'b0;
                            state    <= WRITE;
                        end else begin
                            case (idx)
                                2'd1:    word[15:8]  <= rx_byte;
                                2'd2:    word[23:16] <= rx_byte;
                                default: word[7:0]   <= rx_byte;
                            endcase
                            idx <= idx + 2'd1;
                        end
                    end
                end
                WRITE: begin
                    if (addr == LAST_ADDR) begin
                        overflow <= 1'b1;
                    end else begin
                        addr <= addr + 1'b1;
                    end
                    if (!word_count[ADDR_WIDTH]) begin
                        word_count <= word_count + 1'b1;
                    end
                    // A byte during the final write would start a word that can never be stored.
                    if (take && (addr != LAST_ADDR)) begin
                        word[7:0] <= rx_byte;
                        idx       <= 2'd1;
                        busy      <= 1'b1;
                        state     <= COLLECT;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    idx   <= 2'd0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef UART_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            checksum <= '0;
        end else if (mem_we) begin
            checksum <= checksum + mem_data;
        end
    end
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_uart_word_loader.sv
// tb/tb_uart_word_loader.sv - self-checking bench for uart_word_loader (UART_LOADER_CHECKSUM_EN aware)
module tb_uart_word_loader;

    localparam int AW = 2;
    localparam int T  = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    rx_byte = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_err = 1'b0;
    logic          enable = 1'b1;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_data;
    logic [AW:0]   word_count;
    logic          busy;
    logic          overflow;
    logic [31:0]   checksum;

    int passed = 0;
    int total  = 0;
    int nwe    = 0;
    logic [31:0]   lw_data;
    logic [AW-1:0] lw_addr;

    uart_word_loader #(
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_byte    (rx_byte),
        .rx_valid   (rx_valid),
        .rx_err     (rx_err),
        .enable     (enable),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .word_count (word_count),
        .busy       (busy),
        .overflow   (overflow),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    // Reference model: bytes held so far, edge index of the last accepted byte, next write address.
    logic [7:0]    mq[$];
    int            cyc = 0;
    int            last_cyc = 0;
    logic [AW-1:0] m_addr = '0;
    logic          e_we = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [31:0]   e_data = '0;
    logic [AW:0]   e_cnt = '0;
    logic          e_busy = 1'b0;
    logic          e_ovf = 1'b0;
    logic [31:0]   e_sum = '0;

    task automatic model_step(input logic r, input logic v, input logic [7:0] b,
                              input logic e, input logic en);
        logic acc;
        logic last;
        cyc++;
        if (r) begin
            mq.delete();
            m_addr = '0; e_we = 0; e_addr = '0; e_data = '0;
            e_cnt = '0; e_busy = 0; e_ovf = 0; e_sum = '0;
            return;
        end
        last = e_we && (m_addr == {AW{1'b1}});
        acc  = v && en && !e && !e_ovf && !last;
        if (e_we) begin
            e_sum = e_sum + e_data;
            if (m_addr == {AW{1'b1}}) e_ovf = 1;
            else m_addr = m_addr + 1'b1;
            if (int'(e_cnt) < (1 << AW)) e_cnt = e_cnt + 1'b1;
        end
        // A held partial word dies on enable low, rx_err, or TIMEOUT cycles since its last byte.
        if (mq.size() > 0 && (!en || e || (cyc - last_cyc >= T))) mq.delete();
        e_we = 0;
        if (acc) begin
            mq.push_back(b);
            last_cyc = cyc;
            if (mq.size() == 4) begin
                e_we   = 1;
                e_addr = m_addr;
                e_data = {mq[3], mq[2], mq[1], mq[0]};
                mq.delete();
            end
        end
        e_busy = (mq.size() > 0);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic step(input logic r, input logic v, input logic [7:0] b,
                        input logic e, input logic en);
        reset = r; rx_valid = v; rx_byte = b; rx_err = e; enable = en;
        @(posedge clk);
        model_step(r, v, b, e, en);
        @(negedge clk);
        if (mem_we === 1'b1) begin
            nwe++;
            lw_data = mem_data;
            lw_addr = mem_addr;
        end
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        chk("mem_data", mem_data, e_data);
        chk("word_count", 32'(word_count), 32'(e_cnt));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("overflow", 32'(overflow), 32'(e_ovf));
`ifdef UART_LOADER_CHECKSUM_EN
        chk("checksum", checksum, e_sum);
`else
        chk("checksum", checksum, 32'h0);
`endif
    endtask

    task automatic send(input logic [7:0] b);
        step(0, 1, b, 0, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0, 1);
    endtask

    typedef struct {
        logic r, v; logic [7:0] b; logic e, en;
        logic we; logic [AW-1:0] addr; logic [31:0] data; logic [AW:0] cnt; logic busy;
    } vec_t;

    vec_t tbl[15];

    initial begin
        logic [31:0] exp_sum1;
        int dens;

        tbl[0]  = '{1, 0, 8'h00, 0, 1, 0, 2'd0, 32'h00000000, 3'd0, 0};
        tbl[1]  = '{0, 1, 8'h78, 0, 1, 0, 2'd0, 32'h00000000, 3'd0, 1};
        tbl[2]  = '{0, 1, 8'h56, 0, 1, 0, 2'd0, 32'h00000000, 3'd0, 1};
        tbl[3]  = '{0, 1, 8'h34, 0, 1, 0, 2'd0, 32'h00000000, 3'd0, 1};
        tbl[4]  = '{0, 1, 8'h12, 0, 1, 1, 2'd0, 32'h12345678, 3'd0, 0};
        tbl[5]  = '{0, 1, 8'hEF, 0, 1, 0, 2'd0, 32'h12345678, 3'd1, 1};
        tbl[6]  = '{0, 1, 8'hBE, 0, 1, 0, 2'd0, 32'h12345678, 3'd1, 1};
        tbl[7]  = '{0, 1, 8'hAD, 0, 1, 0, 2'd0, 32'h12345678, 3'd1, 1};
        tbl[8]  = '{0, 1, 8'hDE, 0, 1, 1, 2'd1, 32'hDEADBEEF, 3'd1, 0};
        tbl[9]  = '{0, 0, 8'h00, 0, 1, 0, 2'd1, 32'hDEADBEEF, 3'd2, 0};
        tbl[10] = '{0, 1, 8'h55, 0, 0, 0, 2'd1, 32'hDEADBEEF, 3'd2, 0};
        tbl[11] = '{0, 1, 8'h11, 0, 1, 0, 2'd1, 32'hDEADBEEF, 3'd2, 1};
        tbl[12] = '{0, 1, 8'h22, 1, 1, 0, 2'd1, 32'hDEADBEEF, 3'd2, 0};
        tbl[13] = '{0, 1, 8'h33, 0, 1, 0, 2'd1, 32'hDEADBEEF, 3'd2, 1};
        tbl[14] = '{0, 1, 8'h44, 0, 0, 0, 2'd1, 32'hDEADBEEF, 3'd2, 0};

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].r, tbl[i].v, tbl[i].b, tbl[i].e, tbl[i].en);
            chk($sformatf("tbl%0d_we", i), 32'(mem_we), 32'(tbl[i].we));
            chk($sformatf("tbl%0d_addr", i), 32'(mem_addr), 32'(tbl[i].addr));
            chk($sformatf("tbl%0d_data", i), mem_data, tbl[i].data);
            chk($sformatf("tbl%0d_cnt", i), 32'(word_count), 32'(tbl[i].cnt));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
        end

        // Full timeout: TIMEOUT idle cycles drop the partial word.
        step(1, 0, 8'h00, 0, 1);
        send(8'hAA); send(8'hBB);
        idle(T);
        chk("to_busy_dropped", 32'(busy), 32'h0);
        nwe = 0;
        send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
        chk("to_nwe", nwe, 1);
        chk("to_data", lw_data, 32'hDEADBEEF);
        chk("to_addr", 32'(lw_addr), 32'h0);

        // Byte coincident with expiry becomes byte 0 of a new word.
        step(1, 0, 8'h00, 0, 1);
        send(8'h01); send(8'h02);
        idle(T - 1);
        chk("coin_busy_held", 32'(busy), 32'h1);
        send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
        chk("coin_data", lw_data, 32'hDEADBEEF);

        // Just inside the timeout the word survives.
        step(1, 0, 8'h00, 0, 1);
        send(8'h78); send(8'h56);
        idle(T - 2);
        send(8'h34); send(8'h12);
        chk("surv_data", lw_data, 32'h12345678);

        // Reset mid-word.
        send(8'hAA); send(8'hBB); send(8'hCC);
        step(1, 0, 8'h00, 0, 1);
        nwe = 0;
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        chk("rst_nwe", nwe, 1);
        chk("rst_data", lw_data, 32'h44332211);
        chk("rst_addr", 32'(lw_addr), 32'h0);

        // Address wrap with 5 words.
        step(1, 0, 8'h00, 0, 1);
        nwe = 0;
        for (int w = 0; w < 5; w++)
            for (int k = 0; k < 4; k++) send(8'(w * 4 + k + 1));
        idle(2);
        chk("ovf_nwe", nwe, 4);
        chk("ovf_flag", 32'(overflow), 32'h1);
        chk("ovf_count", 32'(word_count), 32'h4);
        chk("ovf_addr", 32'(mem_addr), 32'h3);
        chk("ovf_data", mem_data, 32'h100F0E0D);

        // Checksum wraps modulo 2^32.
        step(1, 0, 8'h00, 0, 1);
        send(8'h01); send(8'h00); send(8'h00); send(8'h00);
        idle(1);
`ifdef UART_LOADER_CHECKSUM_EN
        exp_sum1 = 32'h1;
`else
        exp_sum1 = 32'h0;
`endif
        chk("sum_first", checksum, exp_sum1);
        send(8'hFF); send(8'hFF); send(8'hFF); send(8'hFF);
        idle(1);
        chk("sum_wrap", checksum, 32'h0);

        // Randomized traffic against the model.
        dens = 50;
        for (int i = 0; i < 4000; i++) begin
            if (i % 64 == 0) begin
                case ($urandom_range(0, 3))
                    0: dens = 3;
                    1: dens = 25;
                    2: dens = 60;
                    default: dens = 100;
                endcase
            end
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 99) < dens,
                 8'($urandom_range(0, 255)),
                 $urandom_range(0, 299) == 0,
                 $urandom_range(0, 149) != 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_word_loader.md
Name: uart_word_loader

Overview:
- Sits directly downstream of the UART byte receiver.
- Packs received bytes into 32-bit little-endian words and writes them sequentially into processor instruction/data memory through a single-cycle write port.
- Used to boot-load programs over serial: bytes in, memory write strobes out.
- Discards partial words after an inter-byte timeout, so an aborted transfer cannot misalign the next one.

Parameters:
- ADDR_WIDTH, 12, width of the word address driven to memory.
- TIMEOUT_CYCLES, 1_000_000, idle clk cycles allowed between bytes of one word before the partial word is discarded (10 ms at 100 MHz).

Ports:
- clk  input  1  system clock (100 MHz).
- reset  input  1  synchronous, active-high reset.
- rx_byte  input  8  received byte from the UART receiver.
- rx_valid  input  1  one-cycle strobe; rx_byte is valid in this cycle.
- rx_err  input  1  sticky framing-error flag from the receiver.
- enable  input  1  loader active; when low, bytes are ignored.
- mem_we  output  1  one-cycle memory write strobe.
- mem_addr  output  ADDR_WIDTH  word address for the write.
- mem_data  output  32  assembled word.
- word_count  output  ADDR_WIDTH+1  number of words written since reset.
- busy  output  1  high while a partial word is held (COLLECT state).
- overflow  output  1  sticky; the address space is exhausted.
- checksum  output  32  see Optional Feature.

Behaviour:
- Reset (synchronous, active-high, highest priority, including mid-word): all outputs 0, state IDLE, byte index 0, address 0, timer 0.
- States:
  - IDLE: on rx_valid && enable && !overflow && !rx_err, store the byte in bits [7:0], set index=1, go to COLLECT.
  - COLLECT: each accepted byte goes to bits [8*idx+7 : 8*idx] and index increments. The 4th byte (idx 3) moves to WRITE and resets the index to 0.
  - WRITE: lasts exactly one cycle. mem_we=1, mem_addr=current address, mem_data=assembled word. The address and word_count increment at the end of this cycle. Next state is IDLE.
- Latency: mem_we is asserted in the cycle after the clk edge at which the 4th rx_valid is sampled.
- Simultaneous events:
  - rx_valid during WRITE is accepted as byte 0 of the next word. The next state is COLLECT with idx=1, and the written word is unaffected.
- Timeout:
  - The timer clears on every accepted byte and counts in COLLECT only.
  - When it reaches TIMEOUT_CYCLES-1, the partial word is discarded, state goes to IDLE, the index is cleared and the address is unchanged.
  - A byte arriving in the same cycle as expiry is accepted as byte 0 of a new word.
- enable:
  - Low in IDLE: rx_valid is ignored.
  - Deasserted in COLLECT: the partial word is discarded and state goes to IDLE next cycle.
  - A WRITE already in progress completes regardless.
- rx_err high: bytes are ignored and any partial word is discarded, as for enable low.
- Address wrap:
  - The write at address 2^ADDR_WIDTH-1 completes normally, then overflow sets and the address stays at its maximum.
  - All further bytes are ignored until reset.
  - word_count saturates at 2^ADDR_WIDTH.
- mem_data and mem_addr hold their last values outside WRITE. Consumers must qualify them with mem_we.

Optional Feature:
- Macro: UART_LOADER_CHECKSUM_EN.
- Defined: checksum is a 32-bit modulo-2^32 sum of every written word. It updates in the cycle after each WRITE and resets to 0. The host compares it against its own sum.
- Undefined: checksum is tied to 0 and no adder is synthesized.

Decomposition:
- Shared package uart_loader_pkg holds:
  - the state encoding (IDLE=2'd0, COLLECT=2'd1, WRITE=2'd2);
  - BYTES_PER_WORD=4;
  - the default TIMEOUT_CYCLES.
- One sub-module, uart_idle_timer: clear/count-enable inputs and a one-cycle expire output, parameterized by TIMEOUT_CYCLES.

Test Plan:
- Bytes 0x78,0x56,0x34,0x12 with enable=1 -> one mem_we pulse, mem_addr=0, mem_data=0x12345678, word_count=1, busy low after the write.
- Eight bytes back-to-back, with the 5th rx_valid coincident with WRITE -> writes at addr 0 and 1, both words correct, no byte lost.
- Two bytes, then TIMEOUT_CYCLES idle cycles, then 0xEF,0xBE,0xAD,0xDE -> single write, mem_data=0xDEADBEEF at addr 0.
- ADDR_WIDTH=2: send 5 words -> 4 writes at addr 0..3, overflow=1, 5th word produces no mem_we, word_count=4.
- Reset asserted after 3 bytes, then 4 new bytes -> write at addr 0 with only the new bytes. With UART_LOADER_CHECKSUM_EN, writing 0x00000001 and 0xFFFFFFFF gives checksum=0x00000000.
- rx_err high mid-word -> partial discarded and no further writes. enable low -> rx_valid ignored.
